// File: rtl/ymz_pcm_rom_bridge.sv
// ============================================================================
// Module      : ymz_pcm_rom_bridge
// Description : YMZ280B sample-ROM port to three PCM SDRAM slots, with a
//               one-entry-per-slot hit cache and fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ymz_pcm_rom_bridge #(
    parameter int PCM_AW   = 22,
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              YMZ_RD,
    input  logic [23:0]       YMZ_ADDR,
    output logic              YMZ_WAITREQ,
    output logic              YMZ_VALID,
    output logic [7:0]        YMZ_DOUT,
    output logic              PCM_CS,
    output logic [PCM_AW-1:0] PCM_ADDR,
    input  logic              PCM_OK,
    input  logic [7:0]        PCM_DOUT,
    output logic              PCM1_CS,
    output logic [PCM_AW-1:0] PCM1_ADDR,
    input  logic              PCM1_OK,
    input  logic [7:0]        PCM1_DOUT,
    output logic              PCM2_CS,
    output logic [PCM_AW-1:0] PCM2_ADDR,
    input  logic              PCM2_OK,
    input  logic [7:0]        PCM2_DOUT,
    output logic              TIMEOUT
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic                r_pend,  w_pend_nx;
    logic [23:0]         r_req,   w_req_nx;
    logic [TO_W-1:0]     r_cnt,   w_cnt_nx;
    logic [2:0]          r_cs,    w_cs_nx;
    logic [7:0]          r_dout,  w_dout_nx;
    logic                r_to,    w_to_nx;
    logic                w_aload;
    logic                w_cwr;

    logic [PCM_AW-1:0]   r_slot_addr [0:2];
    logic                r_cv        [0:2];
    logic [PCM_AW-1:0]   r_ctag      [0:2];
    logic [7:0]          r_cdat      [0:2];

    logic [1:0]          w_bank;
    logic [PCM_AW-1:0]   w_tag;
    logic [2:0]          w_bank_sel;
    logic                w_hit;
    logic [7:0]          w_cdat;
    logic                w_ok;
    logic [7:0]          w_din;

    assign w_bank = r_req[23:22];
    assign w_tag  = r_req[PCM_AW-1:0];

    always_comb begin
        w_bank_sel = 3'b000;
        case (w_bank)
            2'd0:    w_bank_sel = 3'b001;
            2'd1:    w_bank_sel = 3'b010;
            2'd2:    w_bank_sel = 3'b100;
            default: w_bank_sel = 3'b000;
        endcase
    end

    always_comb begin
        w_hit  = 1'b0;
        w_cdat = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (w_bank_sel[i]) begin
                w_hit  = r_cv[i] && (r_ctag[i] == w_tag);
                w_cdat = r_cdat[i];
            end
        end
    end

    // Only the active slot's handshake is observed; r_cs is one-hot or zero.
    assign w_ok  = |(r_cs & {PCM2_OK, PCM1_OK, PCM_OK});
    assign w_din = ({8{r_cs[0]}} & PCM_DOUT)
                 | ({8{r_cs[1]}} & PCM1_DOUT)
                 | ({8{r_cs[2]}} & PCM2_DOUT);

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_req   <= '0;
            r_cnt   <= '0;
            r_cs    <= '0;
            r_dout  <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pend  <= w_pend_nx;
            r_req   <= w_req_nx;
            r_cnt   <= w_cnt_nx;
            r_cs    <= w_cs_nx;
            r_dout  <= w_dout_nx;
            r_to    <= w_to_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pend_nx  = r_pend;
        w_req_nx   = r_req;
        w_cnt_nx   = r_cnt;
        w_cs_nx    = r_cs;
        w_dout_nx  = r_dout;
        w_to_nx    = r_to;
        w_aload    = 1'b0;
        w_cwr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A latched request is resolved one cycle after it is taken.
                if (r_pend) begin
                    w_pend_nx = 1'b0;
                    if (w_bank == 2'd3) begin
                        w_dout_nx  = 8'h00;
                        w_state_nx = S_DONE;
                    end else if (w_hit) begin
                        w_dout_nx  = w_cdat;
                        w_state_nx = S_DONE;
                    end else begin
                        w_cs_nx    = w_bank_sel;
                        w_cnt_nx   = '0;
                        w_aload    = 1'b1;
                        w_state_nx = S_REQ;
                    end
                end else if (YMZ_RD) begin
                    w_req_nx  = YMZ_ADDR;
                    w_pend_nx = 1'b1;
                end
            end
            S_REQ: begin
                // r_cnt == 0 marks the first REQ cycle, where a stale OK is ignored.
                if (w_ok && (r_cnt != '0)) begin
                    w_dout_nx  = w_din;
                    w_cs_nx    = '0;
                    w_cwr      = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_cnt == c_to_last) begin
                    w_dout_nx  = 8'h00;
                    w_cs_nx    = '0;
                    w_to_nx    = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            for (int i = 0; i < 3; i++) begin
                r_slot_addr[i] <= '0;
                r_cv[i]        <= 1'b0;
                r_ctag[i]      <= '0;
                r_cdat[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_aload && w_bank_sel[i]) begin
                    r_slot_addr[i] <= w_tag;
                end
                if (w_cwr && r_cs[i]) begin
                    r_cv[i]   <= 1'b1;
                    r_ctag[i] <= w_tag;
                    r_cdat[i] <= w_din;
                end
            end
        end
    end

    assign YMZ_WAITREQ = (r_state == S_REQ);
    assign YMZ_VALID   = (r_state == S_DONE);
    assign YMZ_DOUT    = r_dout;
    assign TIMEOUT     = r_to;
    assign PCM_CS      = r_cs[0];
    assign PCM1_CS     = r_cs[1];
    assign PCM2_CS     = r_cs[2];
    assign PCM_ADDR    = r_slot_addr[0];
    assign PCM1_ADDR   = r_slot_addr[1];
    assign PCM2_ADDR   = r_slot_addr[2];

endmodule

`default_nettype wire

// File: tb/tb_ymz_pcm_rom_bridge.sv
// ============================================================================
// Module      : tb_ymz_pcm_rom_bridge
// Description : Directed scoreboard bench for ymz_pcm_rom_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ymz_pcm_rom_bridge;

    logic        clk;
    logic        rst;
    logic        rd;
    logic [23:0] addr;
    logic        waitreq;
    logic        valid;
    logic [7:0]  dout;
    logic        cs0, cs1, cs2;
    logic [21:0] a0, a1, a2;
    logic [2:0]  ok;
    logic [7:0]  din [0:2];
    logic        tout;

    int          total;
    int          bad;
    logic [7:0]  exp_q [$];
    logic [7:0]  e;

    ymz_pcm_rom_bridge dut (
        .CLK96       (clk),
        .RESET96     (rst),
        .YMZ_RD      (rd),
        .YMZ_ADDR    (addr),
        .YMZ_WAITREQ (waitreq),
        .YMZ_VALID   (valid),
        .YMZ_DOUT    (dout),
        .PCM_CS      (cs0),
        .PCM_ADDR    (a0),
        .PCM_OK      (ok[0]),
        .PCM_DOUT    (din[0]),
        .PCM1_CS     (cs1),
        .PCM1_ADDR   (a1),
        .PCM1_OK     (ok[1]),
        .PCM1_DOUT   (din[1]),
        .PCM2_CS     (cs2),
        .PCM2_ADDR   (a2),
        .PCM2_OK     (ok[2]),
        .PCM2_DOUT   (din[2]),
        .TIMEOUT     (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] cs_vec();
        return {cs2, cs1, cs0};
    endfunction

    function automatic logic [21:0] slot_addr(input logic [1:0] b);
        case (b)
            2'd0:    return a0;
            2'd1:    return a1;
            default: return a2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse consumes one expected byte.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %0h want none", dout);
            end else begin
                e = exp_q.pop_front();
                chk("dout", {24'h0, dout}, {24'h0, e});
            end
        end
    end

    task automatic miss_read(input logic [23:0] a, input logic [7:0] d, input int dly, input bit noise);
        logic [1:0] b;
        logic [2:0] ecs;
        b   = a[23:22];
        ecs = 3'b001 << b;
        exp_q.push_back(d);
        rd = 1'b1; addr = a;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        chk("miss_cs", cs_vec(), ecs);
        chk("miss_addr", slot_addr(b), a[21:0]);
        chk("miss_waitreq", waitreq, 1'b1);
        if (noise) begin
            ok = ~ecs;
            for (int i = 0; i < 3; i++) din[i] = 8'hEE;
        end
        repeat (dly - 1) @(negedge clk);
        chk("miss_hold_cs", cs_vec(), ecs);
        chk("miss_hold_valid", valid, 1'b0);
        ok = ok | ecs;
        din[b] = d;
        @(negedge clk);
        chk("miss_valid", valid, 1'b1);
        chk("miss_cs_drop", cs_vec(), 3'b000);
        ok = 3'b000;
    endtask

    task automatic hit_read(input logic [23:0] a, input logic [7:0] d);
        exp_q.push_back(d);
        rd = 1'b1; addr = a;
        @(negedge clk); rd = 1'b0;
        chk("hit_valid_early", valid, 1'b0);
        chk("hit_cs_early", cs_vec(), 3'b000);
        @(negedge clk);
        chk("hit_valid", valid, 1'b1);
        chk("hit_cs", cs_vec(), 3'b000);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    initial begin
        int n;
        total = 0; bad = 0;
        rst = 1'b1; rd = 1'b0; addr = '0; ok = '0;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs_vec(), 3'b000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_waitreq", waitreq, 1'b0);
        chk("rst_timeout", tout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        miss_read(24'h412345, 8'hA5, 4, 1'b0);
        @(negedge clk);
        hit_read(24'h412345, 8'hA5);
        miss_read(24'h412346, 8'h3C, 2, 1'b0);
        @(negedge clk);
        hit_read(24'hC00010, 8'h00);
        chk("oor_timeout", tout, 1'b0);

        // OK already high before the request; must be ignored on the first REQ cycle.
        exp_q.push_back(8'h77);
        ok[0] = 1'b1; din[0] = 8'h77;
        rd = 1'b1; addr = 24'h000100;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        chk("stale_cs", cs_vec(), 3'b001);
        @(negedge clk);
        chk("stale_ignored", valid, 1'b0);
        chk("stale_cs_hold", cs_vec(), 3'b001);
        @(negedge clk);
        chk("stale_valid", valid, 1'b1);
        ok = 3'b000;
        @(negedge clk);

        miss_read(24'h000200, 8'h5A, 3, 1'b1);
        @(negedge clk);

        exp_q.push_back(8'h00);
        rd = 1'b1; addr = 24'h800000;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        n = 0;
        while (cs2 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("to_cs_cycles", n, 200);
        chk("to_valid", valid, 1'b1);
        chk("to_flag", tout, 1'b1);
        repeat (3) @(negedge clk);
        chk("to_sticky", tout, 1'b1);
        miss_read(24'h800000, 8'h42, 2, 1'b0);
        chk("to_sticky2", tout, 1'b1);
        @(negedge clk);

        rd = 1'b1; addr = 24'h000300;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        chk("rr_cs_before", cs_vec(), 3'b001);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_cs", cs_vec(), 3'b000);
        chk("rr_addr0", a0, 22'h0);
        chk("rr_addr1", a1, 22'h0);
        chk("rr_addr2", a2, 22'h0);
        chk("rr_valid", valid, 1'b0);
        chk("rr_dout", dout, 8'h00);
        chk("rr_waitreq", waitreq, 1'b0);
        chk("rr_timeout", tout, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        miss_read(24'h412345, 8'h99, 2, 1'b0);
        @(negedge clk);
        hit_read(24'h412345, 8'h99);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
